chess_board_renderer: RTL and testbench

//   Pixel generator downstream of the VGA timing generator. Consumes the pixel counters, display enable and

---
 rtl/chess_board_renderer_if.sv | 22 ++
 rtl/chess_board_renderer.sv | 238 +++++++++++++++++++++++
 tb/tb_chess_board_renderer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_board_renderer_if.sv
// Board RAM and sprite ROM read bus for the chessboard renderer.
// Both memories are synchronous: data follows the address by 1 clk.
interface chess_board_renderer_if;
  logic [5:0]  board_addr;
  logic [3:0]  board_data;
  logic [13:0] sprite_addr;
  logic [11:0] sprite_data;

  modport master (
    output board_addr,
    output sprite_addr,
    input  board_data,
    input  sprite_data
  );

  modport slave (
    input  board_addr,
    input  sprite_addr,
    output board_data,
    output sprite_data
  );
endinterface

// File: rtl/chess_board_renderer.sv
// 8x8 chessboard pixel pipeline: squares, piece sprites, cursor frame,
// selection tint; x/y to rgb latency is 4 clk, syncs re-aligned.
module chess_board_renderer #(
  parameter int          BOARD_X0 = 80,
  parameter int          BOARD_Y0 = 0,
  parameter int          SQ       = 60,
  parameter int          SPR      = 32,
  parameter int          CUR_W    = 3,
  parameter logic [11:0] C_LIGHT  = 12'hEDB,
  parameter logic [11:0] C_DARK   = 12'h853,
  parameter logic [11:0] C_BG     = 12'h222,
  parameter logic [11:0] C_CURSOR = 12'hF00,
  parameter logic [11:0] C_SEL    = 12'h4C4,
  parameter logic [11:0] C_KEY    = 12'hF0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        de_in,
  input  logic        hs_n_in,
  input  logic        vs_n_in,
  input  logic [2:0]  cursor_col,
  input  logic [2:0]  cursor_row,
  input  logic        sel_valid,
  input  logic [2:0]  sel_col,
  input  logic [2:0]  sel_row,
  chess_board_renderer_if.master mem,
  output logic [11:0] rgb,
  output logic        hs_n_out,
  output logic        vs_n_out,
  output logic        de_out
);

  localparam logic [9:0] X0   = 10'(BOARD_X0);
  localparam logic [9:0] Y0   = 10'(BOARD_Y0);
  localparam logic [9:0] BW   = 10'(8 * SQ);
  localparam logic [5:0] SQM1 = 6'(SQ - 1);
  localparam logic [5:0] OFFS = 6'((SQ - SPR) / 2);
  localparam logic [5:0] OFFE = 6'((SQ - SPR) / 2 + SPR);
  localparam logic [5:0] CW   = 6'(CUR_W);
  localparam logic [5:0] CWE  = 6'(SQ - CUR_W);

  // Stage 1 trackers
  logic [2:0] r_col, r_row;
  logic [5:0] r_sub_x, r_sub_y;
  logic       r_x_sync, r_y_sync;
  logic       r1_on;

  // Stage 2 / stage 3 pipeline
  logic [2:0] r2_col, r2_row, r3_col, r3_row;
  logic [5:0] r2_sx, r2_sy, r3_sx, r3_sy;
  logic       r2_on, r3_on, r3_in_spr;
  logic [3:0] r3_piece;

  // Frame-latched cursor / selection
  logic [2:0] r_cur_col, r_cur_row, r_sel_col, r_sel_row;
  logic       r_sel_v;

  // de / sync delay lines
  logic [2:0] r_de, r_hs, r_vs;

  logic [9:0]  w_x_rel, w_y_rel;
  logic        w_x_on, w_y_on, w_x_start, w_y_start;
  logic        w2_in_spr;
  logic [4:0]  w2_spx, w2_spy;
  logic        w_cur_hit, w_spr_hit, w_sel_hit;
  logic [11:0] w_rgb;

  // Unsigned offset compare folds the lower bound into the upper one.
  assign w_x_rel   = x_in - X0;
  assign w_y_rel   = y_in - Y0;
  assign w_x_on    = w_x_rel < BW;
  assign w_y_on    = w_y_rel < BW;
  assign w_x_start = x_in == X0;
  assign w_y_start = (x_in == '0) && (y_in == Y0);

  // Column tracker: restart at the board's left edge, hold off-board
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col    <= '0;
      r_sub_x  <= '0;
      r_x_sync <= 1'b0;
    end else if (w_x_start) begin
      r_col    <= '0;
      r_sub_x  <= '0;
      r_x_sync <= 1'b1;
    end else if (w_x_on) begin
      if (r_sub_x == SQM1) begin
        r_sub_x <= '0;
        if (r_col != 3'd7)
          r_col <= r_col + 3'd1;
      end else begin
        r_sub_x <= r_sub_x + 6'd1;
      end
    end
  end

  // Row tracker: advances once per line at x==0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row    <= '0;
      r_sub_y  <= '0;
      r_y_sync <= 1'b0;
    end else if (w_y_start) begin
      r_row    <= '0;
      r_sub_y  <= '0;
      r_y_sync <= 1'b1;
    end else if ((x_in == '0) && w_y_on) begin
      if (r_sub_y == SQM1) begin
        r_sub_y <= '0;
        if (r_row != 3'd7)
          r_row <= r_row + 3'd1;
      end else begin
        r_sub_y <= r_sub_y + 6'd1;
      end
    end
  end

  // On-board flag, suppressed until both trackers have re-synced
  always_ff @(posedge clk) begin
    if (reset)
      r1_on <= 1'b0;
    else
      r1_on <= w_x_on && w_y_on &&
               (r_x_sync || w_x_start) &&
               (r_y_sync || w_y_start);
  end

  // Capture cursor and selection once per frame to avoid tearing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_col <= '0;
      r_cur_row <= '0;
      r_sel_v   <= 1'b0;
      r_sel_col <= '0;
      r_sel_row <= '0;
    end else if ((x_in == '0) && (y_in == '0)) begin
      r_cur_col <= cursor_col;
      r_cur_row <= cursor_row;
      r_sel_v   <= sel_valid;
      r_sel_col <= sel_col;
      r_sel_row <= sel_row;
    end
  end

  assign mem.board_addr = {r_row, r_col};

  assign w2_in_spr = (r2_sx >= OFFS) && (r2_sx < OFFE) &&
                     (r2_sy >= OFFS) && (r2_sy < OFFE);
  assign w2_spx    = 5'(r2_sx - OFFS);
  assign w2_spy    = 5'(r2_sy - OFFS);

  assign mem.sprite_addr = {mem.board_data, w2_spy, w2_spx};

  // Carry square position alongside the memory reads
  always_ff @(posedge clk) begin
    if (reset) begin
      r2_on     <= 1'b0;
      r2_col    <= '0;
      r2_row    <= '0;
      r2_sx     <= '0;
      r2_sy     <= '0;
      r3_on     <= 1'b0;
      r3_col    <= '0;
      r3_row    <= '0;
      r3_sx     <= '0;
      r3_sy     <= '0;
      r3_in_spr <= 1'b0;
      r3_piece  <= '0;
    end else begin
      r2_on     <= r1_on;
      r2_col    <= r_col;
      r2_row    <= r_row;
      r2_sx     <= r_sub_x;
      r2_sy     <= r_sub_y;
      r3_on     <= r2_on;
      r3_col    <= r2_col;
      r3_row    <= r2_row;
      r3_sx     <= r2_sx;
      r3_sy     <= r2_sy;
      r3_in_spr <= w2_in_spr;
      r3_piece  <= mem.board_data;
    end
  end

  // Delay de/syncs 3 clk so they line up with rgb
  always_ff @(posedge clk) begin
    if (reset) begin
      r_de <= 3'b000;
      r_hs <= 3'b111;
      r_vs <= 3'b111;
    end else begin
      r_de <= {r_de[1:0], de_in};
      r_hs <= {r_hs[1:0], hs_n_in};
      r_vs <= {r_vs[1:0], vs_n_in};
    end
  end

  // Colour select, first matching layer wins
  always_comb begin
    w_rgb     = '0;
    w_cur_hit = (r3_row == r_cur_row) && (r3_col == r_cur_col) &&
                ((r3_sx < CW) || (r3_sx >= CWE) ||
                 (r3_sy < CW) || (r3_sy >= CWE));
    w_spr_hit = r3_in_spr && (r3_piece != '0) &&
                (mem.sprite_data != C_KEY);
    w_sel_hit = r_sel_v && (r3_row == r_sel_row) &&
                (r3_col == r_sel_col);
    if (!r_de[1])
      w_rgb = '0;
    else if (!r3_on)
      w_rgb = C_BG;
    else if (w_cur_hit)
      w_rgb = C_CURSOR;
    else if (w_spr_hit)
      w_rgb = mem.sprite_data;
    else if (w_sel_hit)
      w_rgb = C_SEL;
    else if (!(r3_row[0] ^ r3_col[0]))
      w_rgb = C_LIGHT;
    else
      w_rgb = C_DARK;
  end

  // Output pixel register
  always_ff @(posedge clk) begin
    if (reset)
      rgb <= '0;
    else
      rgb <= w_rgb;
  end

  assign de_out   = r_de[2];
  assign hs_n_out = r_hs[2];
  assign vs_n_out = r_vs[2];

endmodule

// File: tb/tb_chess_board_renderer.sv
// Bench for chess_board_renderer: drives VGA-style counters, models
// board RAM / sprite ROM and checks every output pixel.
module tb_chess_board_renderer;

  localparam logic [11:0] C_LIGHT  = 12'hEDB;
  localparam logic [11:0] C_DARK   = 12'h853;
  localparam logic [11:0] C_BG     = 12'h222;
  localparam logic [11:0] C_CURSOR = 12'hF00;
  localparam logic [11:0] C_SEL    = 12'h4C4;
  localparam logic [11:0] C_KEY    = 12'hF0F;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_in, y_in;
  logic        de_in, hs_n_in, vs_n_in;
  logic [2:0]  cursor_col, cursor_row;
  logic        sel_valid;
  logic [2:0]  sel_col, sel_row;
  logic [11:0] rgb;
  logic        hs_n_out, vs_n_out, de_out;

  chess_board_renderer_if mem();

  chess_board_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .x_in       (x_in),
    .y_in       (y_in),
    .de_in      (de_in),
    .hs_n_in    (hs_n_in),
    .vs_n_in    (vs_n_in),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .sel_valid  (sel_valid),
    .sel_col    (sel_col),
    .sel_row    (sel_row),
    .mem        (mem.master),
    .rgb        (rgb),
    .hs_n_out   (hs_n_out),
    .vs_n_out   (vs_n_out),
    .de_out     (de_out)
  );

  always #5 clk = ~clk;

  logic [3:0] ram [64];
  int         rom_mode;

  function automatic logic [11:0] rom_f(input logic [13:0] a);
    if (rom_mode == 0)
      return (a[4:0] == 5'd0) ? C_KEY : 12'h0F0;
    if (a[4:0] == 5'd0 || a[4:0] == 5'd31)
      return C_KEY;
    return {a[13:10] ^ a[3:0], a[8:5], a[3:0] + a[12:9]};
  endfunction

  always @(posedge clk) begin
    mem.board_data  <= ram[mem.board_addr];
    mem.sprite_data <= rom_f(mem.sprite_addr);
  end

  int n_run, n_fail;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int lc_col, lc_row, ls_v, ls_col, ls_row;
  logic pd, ph, pv;
  int lx, ly;
  logic full [525];

  typedef struct {
    logic [14:0] v;
    int          x;
    int          y;
  } exp_t;
  exp_t q[$];

  function automatic logic [11:0] model_rgb(input int x, input int y);
    int c, r, sx, sy, p;
    logic [11:0] px;
    if (!(x < 640 && y < 480)) return 12'h000;
    if (!(x >= 80 && x < 560 && y < 480)) return C_BG;
    c  = (x - 80) / 60;
    sx = (x - 80) % 60;
    r  = y / 60;
    sy = y % 60;
    if (r == lc_row && c == lc_col &&
        (sx < 3 || sx >= 57 || sy < 3 || sy >= 57))
      return C_CURSOR;
    p = int'(ram[r * 8 + c]);
    if (p != 0 && sx >= 14 && sx < 46 && sy >= 14 && sy < 46) begin
      px = rom_f(14'(p * 1024 + (sy - 14) * 32 + (sx - 14)));
      if (px != C_KEY) return px;
    end
    if (ls_v != 0 && r == ls_row && c == ls_col) return C_SEL;
    return ((r + c) % 2 == 0) ? C_LIGHT : C_DARK;
  endfunction

  task automatic step(input int x, input int y);
    exp_t e;
    logic cd, ch, cv;
    int er, ec;
    @(negedge clk);
    if (q.size() == 4) begin
      e = q.pop_front();
      chk($sformatf("pix(%0d,%0d)", e.x, e.y),
          {17'd0, de_out, hs_n_out, vs_n_out, rgb}, {17'd0, e.v});
    end else begin
      chk("fill", {17'd0, de_out, hs_n_out, vs_n_out, rgb},
          {17'd0, 3'b011, 12'h000});
    end
    if (lx >= 80) begin
      er = (ly < 480) ? ly / 60 : 7;
      ec = ((lx - 80) / 60 > 7) ? 7 : (lx - 80) / 60;
      chk("addr", {26'd0, mem.board_addr}, 32'(er * 8 + ec));
    end
    if (x == 0 && y == 0) begin
      lc_col = int'(cursor_col);
      lc_row = int'(cursor_row);
      ls_v   = int'(sel_valid);
      ls_col = int'(sel_col);
      ls_row = int'(sel_row);
    end
    x_in    = 10'(x);
    y_in    = 10'(y);
    de_in   = pd;
    hs_n_in = ph;
    vs_n_in = pv;
    cd = (x < 640) && (y < 480);
    ch = !(x >= 656 && x < 752);
    cv = !(y == 490 || y == 491);
    pd = cd;
    ph = ch;
    pv = cv;
    e.v = {cd, ch, cv, model_rgb(x, y)};
    e.x = x;
    e.y = y;
    q.push_back(e);
    lx = x;
    ly = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    x_in    = 10'd0;
    y_in    = 10'd600;
    de_in   = 1'b0;
    hs_n_in = 1'b1;
    vs_n_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst", {17'd0, de_out, hs_n_out, vs_n_out, rgb},
          {17'd0, 3'b011, 12'h000});
    end
    reset = 1'b0;
    q.delete();
    pd = 1'b0;
    ph = 1'b1;
    pv = 1'b1;
    lx = 0;
    ly = 0;
  endtask

  task automatic set_full(input int ys[$]);
    for (int i = 0; i < 525; i++) full[i] = 1'b0;
    foreach (ys[i]) full[ys[i]] = 1'b1;
  endtask

  task automatic frame(input int rst_line);
    for (int y = 0; y < 525; y++) begin
      if (y == 260) begin
        cursor_col = 3'($urandom);
        cursor_row = 3'($urandom);
        sel_valid  = 1'($urandom);
        sel_col    = 3'($urandom);
        sel_row    = 3'($urandom);
      end
      if (full[y]) begin
        for (int x = 0; x < 800; x++) begin
          if (y == rst_line && x == 300) begin
            do_reset();
            return;
          end
          step(x, y);
        end
      end else begin
        step(0, y);
      end
    end
  endtask

  task automatic rand_board();
    for (int i = 0; i < 64; i++)
      ram[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
    cursor_col = 3'($urandom);
    cursor_row = 3'($urandom);
    sel_valid  = 1'($urandom);
    sel_col    = 3'($urandom);
    sel_row    = 3'($urandom);
  endtask

  initial begin
    int rl[$];
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    for (int i = 0; i < 64; i++) ram[i] = 4'd0;
    ram[21]    = 4'h3;
    rom_mode   = 0;
    cursor_col = 3'd0;
    cursor_row = 3'd0;
    sel_valid  = 1'b1;
    sel_col    = 3'd7;
    sel_row    = 3'd7;
    do_reset();

    set_full('{0, 1, 2, 3, 10, 57, 59, 60, 120, 134, 140, 150,
               165, 166, 179, 420, 425, 450, 477, 479, 480,
               481, 490});
    frame(-1);

    cursor_col = 3'd0;
    cursor_row = 3'd0;
    set_full('{0, 2, 58, 100, 150, 300, 479});
    frame(-1);

    cursor_col = 3'd4;
    set_full('{0, 1, 59, 300, 425});
    frame(-1);

    rom_mode = 1;
    for (int f = 0; f < 3; f++) begin
      rand_board();
      rl.delete();
      for (int i = 0; i < 6; i++) rl.push_back($urandom_range(0, 524));
      if (f == 1) rl.push_back(250);
      set_full(rl);
      frame((f == 1) ? 250 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
